// File: rtl/i2s_capture.sv
// I2S master receiver: generates bck/ws from clk and captures one 24-bit
// left/right pair per frame, offered to the consumer through a valid/ready hold.
module i2s_capture #(
  parameter int unsigned BCK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        data_in,
  output logic        bck,
  output logic        ws,
  output logic [23:0] sample_left,
  output logic [23:0] sample_right,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun,
  input  logic        overrun_clr
);

  localparam int unsigned DivW = $clog2(BCK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(BCK_DIV - 1);

  logic [DivW-1:0] div_q;
  logic [5:0]      slot_q;
  logic [5:0]      slot_next;
  logic [23:0]     shift_left_q;
  // The last right bit bypasses the register straight into sample_right.
  logic [22:0]     shift_right_q;
  logic [23:0]     right_next;
  logic            tc;
  logic            rise_evt;
  logic            fall_evt;
  logic            cap_left;
  logic            cap_right;
  logic            pair_done;
  logic            accept;

  always_comb begin
    tc         = en && (div_q == DivLast);
    rise_evt   = tc && !bck;
    fall_evt   = tc && bck;
    slot_next  = slot_q + 6'd1;
    cap_left   = rise_evt && (slot_q >= 6'd1) && (slot_q <= 6'd24);
    cap_right  = rise_evt && (slot_q >= 6'd33) && (slot_q <= 6'd55);
    pair_done  = rise_evt && (slot_q == 6'd56);
    right_next = {shift_right_q, data_in};
    accept     = sample_valid && sample_ready;
  end

  // Bit clock, slot counter and shift registers; en low parks everything at frame start.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_q         <= '0;
      bck           <= 1'b0;
      ws            <= 1'b0;
      slot_q        <= '0;
      shift_left_q  <= '0;
      shift_right_q <= '0;
    end else begin
      if (tc) begin
        div_q <= '0;
        bck   <= !bck;
      end else begin
        div_q <= div_q + DivW'(1);
      end
      if (fall_evt) begin
        slot_q <= slot_next;
        ws     <= slot_next[5];
      end
      if (cap_left) begin
        shift_left_q <= {shift_left_q[22:0], data_in};
      end
      if (cap_right) begin
        shift_right_q <= {shift_right_q[21:0], data_in};
      end
    end
  end

  // Output hold: a completed pair is only taken when the slot is free or being freed.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (pair_done && (!sample_valid || sample_ready)) begin
        sample_left  <= shift_left_q;
        sample_right <= right_next;
        sample_valid <= 1'b1;
      end else if (accept) begin
        sample_valid <= 1'b0;
      end
      if (pair_done && sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: doc/i2s_capture.md
I2S_CAPTURE -- requirements
Module: i2s_capture

Interface
REQ-001 Parameter BCK_DIV, default 4, is the number of clk cycles per bck half-period; legal values are >= 2.
REQ-002 clk  input  1  system clock (27 MHz), the sole clock domain.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 en  input  1  capture enable; low forces the idle state.
REQ-005 data_in  input  1  serial audio data from the external ADC, I2S format, MSB first.
REQ-006 bck  output  1  generated bit clock; the block is I2S master.
REQ-007 ws  output  1  generated word select; 0 = left slot, 1 = right slot.
REQ-008 sample_left  output  24  last captured left sample, two's complement.
REQ-009 sample_right  output  24  last captured right sample, two's complement.
REQ-010 sample_valid  output  1  a left/right pair is held on the sample outputs.
REQ-011 sample_ready  input  1  consumer accepts the pair in the current cycle.
REQ-012 overrun  output  1  sticky flag; a completed pair was dropped.
REQ-013 overrun_clr  input  1  single-cycle clear of overrun.

Function
REQ-014 Divider counter runs 0..BCK_DIV-1 while en=1; on terminal count it wraps to 0 and bck toggles.
- Rising event: cycle in which bck goes 0->1.
- Falling event: cycle in which bck goes 1->0.
REQ-015 Slot counter s (6 bits, 0..63) increments on every falling event and wraps 63->0; one frame = 128*BCK_DIV clk cycles (512 at default).
REQ-016 ws SHALL be registered and equal 0 while s is 0..31 and 1 while s is 32..63, so ws changes coincident with bck falling.
REQ-017 On a rising event with s in 1..24, data_in is shifted into the left shift register (MSB first, first shifted bit = bit 23).
- Same rule applies for s in 33..56, into the right shift register.
- All other slots are ignored: s=0, 25..32, 57..63.
REQ-018 On the rising event at s=56 the pair is complete.
- Both shift-register contents are transferred to sample_left/sample_right.
- sample_valid is set, visible 1 clk after that rising event.
REQ-019 sample_valid stays 1, and the sample outputs stay stable, until a cycle with sample_valid=1 and sample_ready=1; sample_valid is 0 on the next cycle.
REQ-020 Pair completes while sample_valid=1 and sample_ready=0:
- The new pair is discarded.
- The outputs keep the old pair.
- overrun is set.
REQ-021 Pair completes in the same cycle as an accepting handshake: the new pair is loaded, sample_valid remains 1, and overrun is unchanged.
REQ-022 overrun stays set until overrun_clr=1 or rst; if a set condition and overrun_clr coincide, set wins.
REQ-023 en=0 on any cycle:
- Next cycle: bck=0, ws=0, divider=0, s=0, shift registers cleared; any partial pair is discarded.
- sample_*, sample_valid, overrun keep their values and the handshake continues to operate.
REQ-024 After en rises, the first bck transition is a rising event BCK_DIV cycles later, with s=0 (no capture); the first left MSB is sampled at the following rising event, s=1.
REQ-025 data_in is sampled directly on the rising-event cycle without a synchronizer, since bck is generated from clk.

Reset
REQ-026 rst=1 on a clk edge forces on the next cycle:
- Outputs: bck=0, ws=0, sample_left=0, sample_right=0, sample_valid=0, overrun=0.
- Internal state: divider=0, s=0, shift registers=0.
REQ-027 rst has priority over en, sample_ready and overrun_clr; rst asserted mid-frame discards the partial pair.
REQ-028 After rst deasserts with en=1, timing follows REQ-024 exactly.

Verification
REQ-029 The bench SHALL cover these directed scenarios (BCK_DIV=4, sample_ready held 1 unless stated):
- Basic capture: ADC model drives left=0x123456, right=0xABCDEF -> sample_valid pulses 1 cycle, outputs match; bck period 8 clk; ws period 512 clk.
- Sign and extremes: left=0x800000, right=0x7FFFFF, then 0xFFFFFF/0x000000 -> exact values captured; slot bits 25..31 driven 1 do not corrupt samples.
- Back-pressure: sample_ready=0 across two frames -> first pair held stable, second pair dropped, overrun=1; sample_ready=1 -> valid drops next cycle; overrun_clr -> overrun=0.
- Simultaneous accept and completion: sample_ready asserted exactly on the completion cycle -> new pair loaded, valid stays 1, overrun stays 0.
- en dropped at s=40 -> bck=0, ws=0 next cycle, no valid pulse; en re-raised -> first rising event after 4 cycles, next full frame captured correctly.
- rst asserted at s=10 with sample_valid=1, overrun=1 -> all outputs zero next cycle; after release, first pair matches driven data.
